// File: rtl/avg_pkg.sv
// Shared AVG vector-list definitions: opcodes, fixed instruction words and field widths.
// Used by avg_list_writer, avg_word_enc and avg_core.
package avg_pkg;

  localparam int unsigned DELTA_W = 13;
  localparam int unsigned Z_W     = 3;
  localparam int unsigned INT_W   = 4;
  localparam int unsigned ADDR_W  = 13;
  localparam int unsigned WORDS_W = 11;
  localparam int unsigned WORD_W  = 16;
  localparam int unsigned NW_W    = 2;

  localparam logic [WORD_W-1:0] WORD_HALT   = 16'h2000;
  localparam logic [WORD_W-1:0] WORD_CNTR   = 16'h8040;
  localparam logic [3:0]        STAT_PREFIX = 4'h6;

  typedef enum logic [1:0] {
    OP_VCTR = 2'd0,
    OP_STAT = 2'd1,
    OP_CNTR = 2'd2,
    OP_HALT = 2'd3
  } avg_op_e;

  typedef struct packed {
    avg_op_e            op;
    logic [DELTA_W-1:0] dx;
    logic [DELTA_W-1:0] dy;
    logic [Z_W-1:0]     z;
    logic [INT_W-1:0]   intensity;
  } avg_cmd_t;

endpackage

// File: rtl/avg_word_enc.sv
// Combinational encoder from a list command to its one or two AVG instruction words.
module avg_word_enc
  import avg_pkg::*;
(
  input  avg_cmd_t          cmd,
  output logic [WORD_W-1:0] word0_c,
  output logic [WORD_W-1:0] word1_c,
  output logic [NW_W-1:0]   nwords_c
);

  always_comb begin
    word0_c  = WORD_HALT;
    word1_c  = '0;
    nwords_c = NW_W'(1);
    case (cmd.op)
      OP_VCTR: begin
        word0_c  = {3'b000, cmd.dy};
        word1_c  = {cmd.z, cmd.dx};
        nwords_c = NW_W'(2);
      end
      OP_STAT: word0_c = {STAT_PREFIX, 4'h0, cmd.intensity, 4'h0};
      OP_CNTR: word0_c = WORD_CNTR;
      OP_HALT: word0_c = WORD_HALT;
      default: word0_c = WORD_HALT;
    endcase
  end

endmodule

// File: rtl/avg_list_writer.sv
// Writes AVG display-list commands into vector RAM as big-endian byte pairs, with HALT
// reserved at the end of the list. Optional STAT de-duplication: AVG_LIST_WRITER_STAT_DEDUP_EN.
module avg_list_writer
  import avg_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 13'h0000,
  parameter int unsigned       LIST_BYTES = 2048
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [DELTA_W-1:0] cmd_dx,
  input  logic [DELTA_W-1:0] cmd_dy,
  input  logic [Z_W-1:0]     cmd_z,
  input  logic [INT_W-1:0]   cmd_int,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [7:0]         wr_data,
  input  logic               wr_ready,
  output logic               busy,
  output logic               done,
  output logic               ovf,
  output logic [WORDS_W-1:0] words
);

  localparam int unsigned TOTAL_WORDS = LIST_BYTES / 2;
  localparam int unsigned CNT_W       = WORDS_W + 1;

  typedef enum logic [2:0] {IDLE, ARMED, WR_HI, WR_LO, NEXT} state_e;

  state_e             state, state_d;
  logic [ADDR_W-1:0]  ptr, ptr_d, ptr_eff;
  logic [WORDS_W-1:0] words_d, words_eff;
  logic [WORD_W-1:0]  cur_word, cur_d, word1_q, word1_d;
  logic               second_q, second_d, halt_q, halt_d;
  logic               ovf_d, wr_en_d, done_d, over;
  logic [ADDR_W-1:0]  wr_addr_d;
  logic [7:0]         wr_data_d;

  avg_cmd_t          cmd;
  logic [WORD_W-1:0] word0_c, word1_c;
  logic [NW_W-1:0]   nwords_c;

  assign cmd = '{op: avg_op_e'(cmd_op), dx: cmd_dx, dy: cmd_dy, z: cmd_z, intensity: cmd_int};

  avg_word_enc u_enc (
    .cmd      (cmd),
    .word0_c  (word0_c),
    .word1_c  (word1_c),
    .nwords_c (nwords_c)
  );

`ifdef AVG_LIST_WRITER_STAT_DEDUP_EN
  logic [INT_W-1:0] last_int, last_int_d;
  logic             last_valid, last_valid_d, last_valid_eff;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      words     <= '0;
      ovf       <= 1'b0;
      cur_word  <= '0;
      word1_q   <= '0;
      second_q  <= 1'b0;
      halt_q    <= 1'b0;
      cmd_ready <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef AVG_LIST_WRITER_STAT_DEDUP_EN
      last_int   <= '0;
      last_valid <= 1'b0;
`endif
    end else begin
      state     <= state_d;
      ptr       <= ptr_d;
      words     <= words_d;
      ovf       <= ovf_d;
      cur_word  <= cur_d;
      word1_q   <= word1_d;
      second_q  <= second_d;
      halt_q    <= halt_d;
      cmd_ready <= (state_d == ARMED);
      wr_en     <= wr_en_d;
      wr_addr   <= wr_addr_d;
      wr_data   <= wr_data_d;
      busy      <= (state_d != IDLE) && (state_d != ARMED);
      done      <= done_d;
`ifdef AVG_LIST_WRITER_STAT_DEDUP_EN
      last_int   <= last_int_d;
      last_valid <= last_valid_d;
`endif
    end
  end

  // Next-state and next-output logic; start in ARMED takes effect for a same-cycle capture.
  always_comb begin
    state_d   = state;
    ptr_d     = ptr;
    words_d   = words;
    ovf_d     = ovf;
    cur_d     = cur_word;
    word1_d   = word1_q;
    second_d  = second_q;
    halt_d    = halt_q;
    wr_en_d   = wr_en;
    wr_addr_d = wr_addr;
    wr_data_d = wr_data;
    done_d    = 1'b0;
    ptr_eff   = ptr;
    words_eff = words;
    over      = 1'b0;
`ifdef AVG_LIST_WRITER_STAT_DEDUP_EN
    last_int_d     = last_int;
    last_valid_d   = last_valid;
    last_valid_eff = last_valid;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          state_d = ARMED;
          ptr_d   = BASE_ADDR;
          words_d = '0;
          ovf_d   = 1'b0;
`ifdef AVG_LIST_WRITER_STAT_DEDUP_EN
          last_valid_d = 1'b0;
`endif
        end
      end
      ARMED: begin
        if (start) begin
          ptr_d     = BASE_ADDR;
          words_d   = '0;
          ovf_d     = 1'b0;
          ptr_eff   = BASE_ADDR;
          words_eff = '0;
`ifdef AVG_LIST_WRITER_STAT_DEDUP_EN
          last_valid_d   = 1'b0;
          last_valid_eff = 1'b0;
`endif
        end
        if (cmd_valid) begin
          // The last list word is kept for HALT; any other command that would use it becomes HALT.
          over = (cmd.op != OP_HALT) &&
                 ((CNT_W'(nwords_c) + CNT_W'(words_eff) + CNT_W'(1)) > CNT_W'(TOTAL_WORDS));
`ifdef AVG_LIST_WRITER_STAT_DEDUP_EN
          if (!(cmd.op == OP_STAT && last_valid_eff && cmd.intensity == last_int)) begin
`else
          begin
`endif
            state_d   = WR_HI;
            wr_en_d   = 1'b1;
            wr_addr_d = ptr_eff;
            if (over) begin
              cur_d    = WORD_HALT;
              halt_d   = 1'b1;
              second_d = 1'b0;
              ovf_d    = 1'b1;
            end else begin
              cur_d    = word0_c;
              word1_d  = word1_c;
              second_d = (nwords_c == NW_W'(2));
              halt_d   = (cmd.op == OP_HALT);
`ifdef AVG_LIST_WRITER_STAT_DEDUP_EN
              if (cmd.op == OP_STAT) begin
                last_int_d   = cmd.intensity;
                last_valid_d = 1'b1;
              end
`endif
            end
            wr_data_d = cur_d[15:8];
          end
        end
      end
      WR_HI: begin
        if (wr_ready) begin
          state_d   = WR_LO;
          wr_addr_d = wr_addr + ADDR_W'(1);
          wr_data_d = cur_word[7:0];
        end
      end
      WR_LO: begin
        if (wr_ready) begin
          wr_en_d = 1'b0;
          ptr_d   = ptr + ADDR_W'(2);
          words_d = words + WORDS_W'(1);
          if (halt_q) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else if (second_q) begin
            state_d  = NEXT;
            second_d = 1'b0;
            cur_d    = word1_q;
          end else begin
            state_d = ARMED;
          end
        end
      end
      NEXT: begin
        state_d   = WR_HI;
        wr_en_d   = 1'b1;
        wr_addr_d = ptr;
        wr_data_d = cur_word[15:8];
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_avg_list_writer.sv
// Scoreboard bench for avg_list_writer: default-size list (instance 0) and an 8-byte list (instance 1).
`timescale 1ns/1ps
module tb_avg_list_writer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start_s[2], cmd_valid_s[2], cmd_ready_s[2], wr_ready_s[2];
  logic [1:0]  op_s[2];
  logic [12:0] dx_s[2], dy_s[2];
  logic [2:0]  z_s[2];
  logic [3:0]  int_s[2];
  logic        wr_en_s[2], busy_s[2], done_s[2], ovf_s[2];
  logic [12:0] wr_addr_s[2];
  logic [7:0]  wr_data_s[2];
  logic [10:0] words_s[2];

  int n_checks = 0;
  int n_fail   = 0;
  logic [20:0] q0[$];
  logic [20:0] q1[$];

  avg_list_writer dut (
    .clk(clk), .rst(rst), .start(start_s[0]), .cmd_valid(cmd_valid_s[0]), .cmd_ready(cmd_ready_s[0]),
    .cmd_op(op_s[0]), .cmd_dx(dx_s[0]), .cmd_dy(dy_s[0]), .cmd_z(z_s[0]), .cmd_int(int_s[0]),
    .wr_en(wr_en_s[0]), .wr_addr(wr_addr_s[0]), .wr_data(wr_data_s[0]), .wr_ready(wr_ready_s[0]),
    .busy(busy_s[0]), .done(done_s[0]), .ovf(ovf_s[0]), .words(words_s[0])
  );

  avg_list_writer #(.BASE_ADDR(13'h0000), .LIST_BYTES(8)) dut8 (
    .clk(clk), .rst(rst), .start(start_s[1]), .cmd_valid(cmd_valid_s[1]), .cmd_ready(cmd_ready_s[1]),
    .cmd_op(op_s[1]), .cmd_dx(dx_s[1]), .cmd_dy(dy_s[1]), .cmd_z(z_s[1]), .cmd_int(int_s[1]),
    .wr_en(wr_en_s[1]), .wr_addr(wr_addr_s[1]), .wr_data(wr_data_s[1]), .wr_ready(wr_ready_s[1]),
    .busy(busy_s[1]), .done(done_s[1]), .ovf(ovf_s[1]), .words(words_s[1])
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Monitors: every completed byte write is popped from its instance's queue and compared.
  always @(negedge clk) begin
    if (!rst && wr_en_s[0] && wr_ready_s[0]) begin
      if (q0.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL wr0_unexpected: got %0h:%0h expected no write", wr_addr_s[0], wr_data_s[0]);
      end else chk("wr0", {11'd0, wr_addr_s[0], wr_data_s[0]}, {11'd0, q0.pop_front()});
    end
  end

  always @(negedge clk) begin
    if (!rst && wr_en_s[1] && wr_ready_s[1]) begin
      if (q1.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL wr1_unexpected: got %0h:%0h expected no write", wr_addr_s[1], wr_data_s[1]);
      end else chk("wr1", {11'd0, wr_addr_s[1], wr_data_s[1]}, {11'd0, q1.pop_front()});
    end
  end

  task automatic exp_wr(input int k, input logic [12:0] a, input logic [7:0] d);
    if (k == 0) q0.push_back({a, d}); else q1.push_back({a, d});
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start(input int k);
    start_s[k] = 1'b1; tick(); start_s[k] = 1'b0;
  endtask

  task automatic send(input int k, input logic [1:0] op, input logic [12:0] dx, input logic [12:0] dy,
                      input logic [2:0] z, input logic [3:0] it);
    bit ok = 0;
    op_s[k] = op; dx_s[k] = dx; dy_s[k] = dy; z_s[k] = z; int_s[k] = it;
    cmd_valid_s[k] = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (cmd_ready_s[k]) begin tick(); ok = 1; break; end
      tick();
    end
    cmd_valid_s[k] = 1'b0;
    if (!ok) begin n_checks++; n_fail++; $display("FAIL send_timeout: got no cmd_ready expected handshake"); end
  endtask

  task automatic wait_armed(input int k);
    bit ok = 0;
    for (int i = 0; i < 50; i++) begin
      if (cmd_ready_s[k]) begin ok = 1; break; end
      tick();
    end
    if (!ok) begin n_checks++; n_fail++; $display("FAIL armed_timeout: got cmd_ready=0 expected 1"); end
  endtask

  task automatic wait_done(input int k);
    bit ok = 0;
    for (int i = 0; i < 50; i++) begin
      if (done_s[k]) begin ok = 1; break; end
      tick();
    end
    if (!ok) begin n_checks++; n_fail++; $display("FAIL done_timeout: got done=0 expected pulse"); end
  endtask

  task automatic chk_reset(input int k);
    chk("rst_cmd_ready", 32'(cmd_ready_s[k]), 0);
    chk("rst_wr_en",     32'(wr_en_s[k]), 0);
    chk("rst_wr_addr",   32'(wr_addr_s[k]), 0);
    chk("rst_wr_data",   32'(wr_data_s[k]), 0);
    chk("rst_busy",      32'(busy_s[k]), 0);
    chk("rst_done",      32'(done_s[k]), 0);
    chk("rst_ovf",       32'(ovf_s[k]), 0);
    chk("rst_words",     32'(words_s[k]), 0);
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      start_s[k] = 0; cmd_valid_s[k] = 0; wr_ready_s[k] = 0;
      op_s[k] = 0; dx_s[k] = 0; dy_s[k] = 0; z_s[k] = 0; int_s[k] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk_reset(0);
    chk_reset(1);
    rst = 1'b0;

    // VCTR dx=0010 dy=1FF0 z=5 -> 00:1F 01:F0 02:A0 03:10
    wr_ready_s[0] = 1'b1;
    pulse_start(0);
    chk("armed_ready", 32'(cmd_ready_s[0]), 1);
    exp_wr(0, 13'd0, 8'h1F); exp_wr(0, 13'd1, 8'hF0); exp_wr(0, 13'd2, 8'hA0); exp_wr(0, 13'd3, 8'h10);
    send(0, 2'd0, 13'h0010, 13'h1FF0, 3'd5, 4'd0);
    chk("first_wr_latency", {19'd0, wr_en_s[0], wr_addr_s[0]}, {19'd0, 1'b1, 13'd0});
    chk("busy_writing", 32'(busy_s[0]), 1);
    chk("ready_writing", 32'(cmd_ready_s[0]), 0);
    wait_armed(0);
    chk("vctr_words", 32'(words_s[0]), 2);
    chk("vctr_busy", 32'(busy_s[0]), 0);

    // STAT 9 then HALT -> 60 90 20 00, done for one clock
    pulse_start(0);
    chk("restart_words", 32'(words_s[0]), 0);
    exp_wr(0, 13'd0, 8'h60); exp_wr(0, 13'd1, 8'h90); exp_wr(0, 13'd2, 8'h20); exp_wr(0, 13'd3, 8'h00);
    send(0, 2'd1, 13'd0, 13'd0, 3'd0, 4'd9);
    wait_armed(0);
    send(0, 2'd3, 13'd0, 13'd0, 3'd0, 4'd0);
    wait_done(0);
    chk("halt_busy", 32'(busy_s[0]), 0);
    chk("halt_words", 32'(words_s[0]), 2);
    chk("halt_ovf", 32'(ovf_s[0]), 0);
    tick();
    chk("done_one_clk", 32'(done_s[0]), 0);
    op_s[0] = 2'd2; cmd_valid_s[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("idle_stall", 32'(cmd_ready_s[0]), 0);
      tick();
    end

    // start with cmd_valid in IDLE arms only; then wr_ready held low 5 clks on the high byte
    wr_ready_s[0] = 1'b0;
    exp_wr(0, 13'd0, 8'h80); exp_wr(0, 13'd1, 8'h40);
    pulse_start(0);
    chk("arm_only_ready", 32'(cmd_ready_s[0]), 1);
    chk("arm_only_wr_en", 32'(wr_en_s[0]), 0);
    tick();
    cmd_valid_s[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_hold", {11'd0, wr_en_s[0], wr_addr_s[0], wr_data_s[0]}, {11'd0, 1'b1, 13'd0, 8'h80});
      tick();
    end
    wr_ready_s[0] = 1'b1;
    wait_armed(0);
    chk("cntr_words", 32'(words_s[0]), 1);

    // rst between the high and low byte of CNTR
    wr_ready_s[0] = 1'b0;
    pulse_start(0);
    exp_wr(0, 13'd0, 8'h80);
    send(0, 2'd2, 13'd0, 13'd0, 3'd0, 4'd0);
    wr_ready_s[0] = 1'b1;
    tick();
    wr_ready_s[0] = 1'b0;
    chk("mid_word_lo", {19'd0, wr_en_s[0], wr_addr_s[0]}, {19'd0, 1'b1, 13'd1});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset(0);
    wr_ready_s[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("post_rst_no_wr", 32'(wr_en_s[0]), 0);
      tick();
    end

    // LIST_BYTES=8: second VCTR becomes HALT at addr 4 with ovf
    wr_ready_s[1] = 1'b1;
    pulse_start(1);
    exp_wr(1, 13'd0, 8'h00); exp_wr(1, 13'd1, 8'h02); exp_wr(1, 13'd2, 8'h20); exp_wr(1, 13'd3, 8'h01);
    exp_wr(1, 13'd4, 8'h20); exp_wr(1, 13'd5, 8'h00);
    send(1, 2'd0, 13'd1, 13'd2, 3'd1, 4'd0);
    wait_armed(1);
    chk("ovf_first_words", 32'(words_s[1]), 2);
    chk("ovf_first_flag", 32'(ovf_s[1]), 0);
    send(1, 2'd0, 13'd3, 13'd4, 3'd2, 4'd0);
    wait_done(1);
    chk("ovf_flag", 32'(ovf_s[1]), 1);
    chk("ovf_words", 32'(words_s[1]), 3);
    tick();
    op_s[1] = 2'd0; cmd_valid_s[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("ovf_stall", 32'(cmd_ready_s[1]), 0);
      tick();
    end
    cmd_valid_s[1] = 1'b0;
    chk("ovf_sticky", 32'(ovf_s[1]), 1);

`ifdef AVG_LIST_WRITER_STAT_DEDUP_EN
    // STAT 7, STAT 7, STAT 3 -> 60 70, 60 30
    pulse_start(0);
    exp_wr(0, 13'd0, 8'h60); exp_wr(0, 13'd1, 8'h70); exp_wr(0, 13'd2, 8'h60); exp_wr(0, 13'd3, 8'h30);
    send(0, 2'd1, 13'd0, 13'd0, 3'd0, 4'd7);
    wait_armed(0);
    send(0, 2'd1, 13'd0, 13'd0, 3'd0, 4'd7);
    wait_armed(0);
    send(0, 2'd1, 13'd0, 13'd0, 3'd0, 4'd3);
    wait_armed(0);
    chk("dedup_words", 32'(words_s[0]), 2);
`endif

    repeat (4) tick();
    chk("q0_drained", 32'(q0.size()), 0);
    chk("q1_drained", 32'(q1.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
